// File: rtl/cargador_pkg.sv
// cargador_pkg: shared types and constants for the RGB run-time loader.
// State encoding, colour indices (shared with temporizador flags), the
// busy code shown on sel, and the lockout counter width.
package cargador_pkg;

   typedef enum logic [2:0] {
      LOAD_R,
      LOAD_G,
      LOAD_B,
      FIRE,
      BUSY
   } estado_t;

   localparam logic [1:0] COL_R    = 2'd2;
   localparam logic [1:0] COL_G    = 2'd1;
   localparam logic [1:0] COL_B    = 2'd0;
   localparam logic [1:0] SEL_BUSY = 2'd3;

   localparam int unsigned CNT_W = 7;

endpackage

// File: rtl/cargador_rgb_antirrebote.sv
// antirrebote: button conditioning for cargador_rgb.
// 2-FF synchronizer, optional debounce (CARGADOR_DEBOUNCE_EN) and a
// registered rising-edge detector producing a one-cycle press pulse.
module antirrebote #(
   parameter int unsigned DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press
);

   logic sinc_a;
   logic sinc_b;
   logic nivel;
   logic nivel_q;

   if (DEB_CYCLES == 0) begin : g_deb_chk
      $error("antirrebote: DEB_CYCLES must be nonzero");
   end

   // two-flop synchronizer for the asynchronous button
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sinc_a <= 1'b0;
         sinc_b <= 1'b0;
      end else begin
         sinc_a <= btn;
         sinc_b <= sinc_a;
      end
   end

`ifdef CARGADOR_DEBOUNCE_EN
   localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
   logic [CW-1:0] cuenta;

   // count consecutive high samples; any low sample restarts the count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cuenta <= '0;
      end else if (!sinc_b) begin
         cuenta <= '0;
      end else if (cuenta != CW'(DEB_CYCLES)) begin
         cuenta <= cuenta + 1'b1;
      end
   end

   assign nivel = (cuenta == CW'(DEB_CYCLES));
`else
   assign nivel = sinc_b;
`endif

   // registered rising-edge detect: one pulse per accepted press
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nivel_q <= 1'b0;
         press   <= 1'b0;
      end else begin
         nivel_q <= nivel;
         press   <= nivel & ~nivel_q;
      end
   end

endmodule

// File: rtl/cargador_rgb.sv
// cargador_rgb: operator loader for the three per-colour motor run times.
// Captures R, G, B intensities one press at a time, scales and saturates
// them, fires a one-cycle enter pulse and locks out the operator until
// temporizador finishes. Optional macro: CARGADOR_DEBOUNCE_EN.
module cargador_rgb
   import cargador_pkg::*;
#(
   parameter int unsigned UNIT       = 2,
   parameter int unsigned MAX_CICLOS = 15,
   parameter int unsigned DEB_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn,
   input  logic [2:0] sw,
   output logic       enter,
   output logic [4:0] ciclos_R,
   output logic [4:0] ciclos_G,
   output logic [4:0] ciclos_B,
   output logic [1:0] sel,
   output logic       busy
);

   localparam int unsigned PW = 3 + $clog2(UNIT + 1);

   if (MAX_CICLOS > 15 || UNIT == 0) begin : g_param_chk
      $error("cargador_rgb: MAX_CICLOS must be <= 15 and UNIT nonzero");
   end

   logic              press;
   estado_t           estado;
   logic [PW-1:0]     prod;
   logic [4:0]        escalado;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  carga;

   antirrebote #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_antirrebote (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn),
      .press(press)
   );

   // scale the switch value and saturate before narrowing to 5 bits
   always_comb begin
      prod     = PW'(sw) * PW'(UNIT);
      escalado = (prod > PW'(MAX_CICLOS)) ? 5'(MAX_CICLOS) : 5'(prod);
   end

   // FIRE counts as the first lockout cycle, so BUSY is loaded one short
   always_comb begin
      carga = CNT_W'(ciclos_R) + CNT_W'(ciclos_G) + CNT_W'(ciclos_B) + CNT_W'(2);
   end

   // load sequence, fire pulse and lockout, all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado   <= LOAD_R;
         enter    <= 1'b0;
         ciclos_R <= '0;
         ciclos_G <= '0;
         ciclos_B <= '0;
         sel      <= COL_R;
         busy     <= 1'b0;
         cnt      <= '0;
      end else begin
         case (estado)
            LOAD_R: begin
               if (press) begin
                  ciclos_R <= escalado;
                  sel      <= COL_G;
                  estado   <= LOAD_G;
               end
            end
            LOAD_G: begin
               if (press) begin
                  ciclos_G <= escalado;
                  sel      <= COL_B;
                  estado   <= LOAD_B;
               end
            end
            LOAD_B: begin
               if (press) begin
                  ciclos_B <= escalado;
                  sel      <= SEL_BUSY;
                  busy     <= 1'b1;
                  enter    <= 1'b1;
                  estado   <= FIRE;
               end
            end
            FIRE: begin
               enter  <= 1'b0;
               cnt    <= carga;
               estado <= BUSY;
            end
            BUSY: begin
               if (cnt <= CNT_W'(1)) begin
                  cnt    <= '0;
                  busy   <= 1'b0;
                  sel    <= COL_R;
                  estado <= LOAD_R;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               enter  <= 1'b0;
               busy   <= 1'b0;
               sel    <= COL_R;
               cnt    <= '0;
               estado <= LOAD_R;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cargador_rgb.sv
// tb_cargador_rgb: scoreboard bench for cargador_rgb.
// Two instances (UNIT = 2 and UNIT = 4); expected captures and lockout
// lengths are queued as presses are driven and checked as sel/busy move.
module tb_cargador_rgb;

   localparam int unsigned DEB = 16;
`ifdef CARGADOR_DEBOUNCE_EN
   localparam int unsigned LAT  = DEB + 5;
   localparam int unsigned HOLD = DEB + 10;
`else
   localparam int unsigned LAT  = 5;
   localparam int unsigned HOLD = 8;
`endif
   localparam int unsigned LOW = 6;

   logic       clk;
   logic       rst_n;
   logic       btn;
   logic       btn4;
   logic [2:0] sw;

   logic       enter2, busy2, enter4, busy4;
   logic [4:0] cr2, cg2, cb2, cr4, cg4, cb4;
   logic [1:0] sel2, sel4;

   bit         act;
   logic       m_enter, m_busy;
   logic [4:0] m_cr, m_cg, m_cb;
   logic [1:0] m_sel;

   int unsigned n_cmp;
   int unsigned n_bad;
   int unsigned q_cap[$];
   int unsigned q_busy[$];
   int unsigned last_r, last_g, last_b;
   logic [1:0]  prev_sel;
   int unsigned busy_len;
   int unsigned ent_n;

   cargador_rgb #(.UNIT(2), .MAX_CICLOS(15), .DEB_CYCLES(DEB)) dut2 (
      .clk(clk), .rst_n(rst_n), .btn(btn), .sw(sw), .enter(enter2),
      .ciclos_R(cr2), .ciclos_G(cg2), .ciclos_B(cb2), .sel(sel2), .busy(busy2)
   );

   cargador_rgb #(.UNIT(4), .MAX_CICLOS(15), .DEB_CYCLES(DEB)) dut4 (
      .clk(clk), .rst_n(rst_n), .btn(btn4), .sw(sw), .enter(enter4),
      .ciclos_R(cr4), .ciclos_G(cg4), .ciclos_B(cb4), .sel(sel4), .busy(busy4)
   );

   assign m_enter = act ? enter4 : enter2;
   assign m_busy  = act ? busy4  : busy2;
   assign m_cr    = act ? cr4    : cr2;
   assign m_cg    = act ? cg4    : cg2;
   assign m_cb    = act ? cb4    : cb2;
   assign m_sel   = act ? sel4   : sel2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int unsigned scale(input int unsigned v, input int unsigned unit);
      int unsigned p;
      p = v * unit;
      return (p > 15) ? 15 : p;
   endfunction

   function automatic int unsigned pop_cap();
      if (q_cap.size() == 0) return 32'hFFFF_FFFF;
      return q_cap.pop_front();
   endfunction

   function automatic int unsigned pop_busy();
      if (q_busy.size() == 0) return 32'hFFFF_FFFF;
      return q_busy.pop_front();
   endfunction

   // monitor: compare captures when sel advances, lockout when busy drops
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_sel = 2'd2;
         busy_len = 0;
         ent_n    = 0;
      end else begin
         if (m_sel != prev_sel) begin
            chk("sel_step", m_sel, 2'(prev_sel - 2'd1));
            case (prev_sel)
               2'd2: begin last_r = pop_cap(); chk("cap_R", m_cr, last_r); end
               2'd1: begin last_g = pop_cap(); chk("cap_G", m_cg, last_g); end
               2'd0: begin
                  last_b = pop_cap();
                  chk("cap_B", m_cb, last_b);
                  chk("enter_fire", m_enter, 1);
               end
               default: ;
            endcase
            prev_sel = m_sel;
         end
         if (m_enter) ent_n++;
         if (m_busy) begin
            busy_len++;
         end else if (busy_len != 0) begin
            chk("busy_len", busy_len, pop_busy());
            chk("enter_count", ent_n, 1);
            chk("hold_R", m_cr, last_r);
            chk("hold_G", m_cg, last_g);
            chk("hold_B", m_cb, last_b);
            busy_len = 0;
            ent_n    = 0;
         end
      end
   end

   task automatic drive_btn(input logic v);
      if (act) btn4 = v;
      else     btn  = v;
   endtask

   // one clean press; latency to the sel change is checked in LOAD states
   task automatic press(input int unsigned v);
      logic [1:0]  s0;
      int unsigned seen;
      sw   = 3'(v);
      s0   = m_sel;
      seen = 0;
      drive_btn(1'b1);
      for (int unsigned i = 1; i <= HOLD; i++) begin
         @(negedge clk);
         if (seen == 0 && m_sel != s0) seen = i;
      end
      chk("press_latency", seen, LAT);
      @(posedge clk); #1;
      drive_btn(1'b0);
      repeat (LOW) @(posedge clk);
      #1;
   endtask

   task automatic seq(input int unsigned a, input int unsigned b, input int unsigned c);
      int unsigned u;
      u = act ? 4 : 2;
      q_cap.push_back(scale(a, u));
      press(a);
      q_cap.push_back(scale(b, u));
      press(b);
      q_cap.push_back(scale(c, u));
      q_busy.push_back(scale(a, u) + scale(b, u) + scale(c, u) + 3);
      press(c);
   endtask

   task automatic wait_idle();
      int unsigned n;
      n = 0;
      while ((q_cap.size() != 0 || q_busy.size() != 0 || m_busy || m_sel != 2'd2) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) chk("idle_timeout", q_cap.size() + q_busy.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_enter"}, m_enter, 0);
      chk({tag, "_R"}, m_cr, 0);
      chk({tag, "_G"}, m_cg, 0);
      chk({tag, "_B"}, m_cb, 0);
      chk({tag, "_sel"}, m_sel, 2);
      chk({tag, "_busy"}, m_busy, 0);
   endtask

   initial begin
      int unsigned n;
      n_cmp  = 0;
      n_bad  = 0;
      act    = 1'b0;
      rst_n  = 1'b0;
      btn    = 1'b0;
      btn4   = 1'b0;
      sw     = 3'd0;
      last_r = 0;
      last_g = 0;
      last_b = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset("rst2");
      chk("rst4_sel", sel4, 2);
      chk("rst4_R", cr4, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // basic load: 6, 10, 2 and a 21-cycle lockout
      seq(3, 5, 1);
      wait_idle();

      // zero intensities: minimum lockout
      seq(0, 0, 0);
      wait_idle();

      // long lockout with presses thrown at it
      seq(7, 7, 7);
      sw = 3'd1;
      for (int k = 0; k < 5; k++) begin
         btn = 1'b1;
         repeat (2) @(posedge clk);
         #1;
         btn = 1'b0;
         repeat (2) @(posedge clk);
         #1;
      end
      wait_idle();

`ifdef CARGADOR_DEBOUNCE_EN
      // bouncing button: only the final stable hold may register
      sw = 3'd5;
      for (int k = 0; k < 7; k++) begin
         btn = 1'b0;
         repeat (3) @(posedge clk);
         #1;
         btn = 1'b1;
         repeat (3) @(posedge clk);
         #1;
      end
      btn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("bounce_no_capture", m_sel, 2);
      seq(5, 3, 2);
      wait_idle();
`endif

      // reset in the middle of a lockout, then a normal load
      seq(2, 4, 6);
      n = 0;
      while (!m_busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("reached_busy", m_busy, 1);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      q_cap.delete();
      q_busy.delete();
      @(negedge clk);
      chk_reset("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      seq(1, 2, 3);
      wait_idle();

      // UNIT = 4 instance: every colour saturates to 15, 48-cycle lockout
      act = 1'b1;
      @(posedge clk); #1;
      seq(7, 7, 7);
      wait_idle();

      chk("cap_queue_empty", q_cap.size(), 0);
      chk("busy_queue_empty", q_busy.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

endmodule
